// File: rtl/rng_guess_pkg.sv
// Shared types and constants for the digit-guessing controller.
package rng_guess_pkg;

    localparam int DIGITS = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;

    // Element [DIGITS-1] holds the thousands digit.
    typedef logic [DIGITS-1:0][3:0] digits_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_ENTRY,
        S_CHECK,
        S_WIN,
        S_LOCK
    } state_e;

endpackage

// File: rtl/guess_score.sv
// Combinational scorer: counts positions where the guess equals the secret.
module guess_score
    import rng_guess_pkg::*;
(
    input  digits_t    secret_i,
    input  digits_t    guess_i,
    output logic [2:0] hits_o,
    output logic       match_o
);

    always_comb begin
        hits_o = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (secret_i[i] == guess_i[i]) begin
                hits_o = hits_o + 3'd1;
            end
        end
        match_o = (hits_o == 3'(DIGITS));
    end

endmodule

// File: rtl/rng_guess_ctrl.sv
// Round controller: fetches a 4-digit secret from the RNG, collects keyed
// guesses digit by digit, scores them and reports win/lock status.
//
//   state   | meaning
//   --------+----------------------------------------------
//   S_IDLE  | after reset, waiting for start
//   S_REQ   | fetch_num pulse to the RNG
//   S_WAIT  | RNG digits settle, latched into secret at exit
//   S_ENTRY | collecting guess digits
//   S_CHECK | scoring the completed guess
//   S_WIN   | guess matched, round over
//   S_LOCK  | tries exhausted, round over
module rng_guess_ctrl
    import rng_guess_pkg::*;
#(
    parameter int unsigned MAX_TRIES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       key_clear,
    input  logic [3:0] rng_d1000,
    input  logic [3:0] rng_d100,
    input  logic [3:0] rng_d10,
    input  logic [3:0] rng_d1,
    output logic       fetch_num,
    output logic       busy,
    output logic [2:0] entry_count,
    output logic [3:0] attempts,
    output logic       result_valid,
    output logic       result_match,
    output logic [2:0] hits,
    output logic       key_err,
    output logic       locked,
    output logic       won
);

    state_e     state_q, state_d;
    digits_t    secret_q, secret_d;
    digits_t    guess_q, guess_d;
    logic [2:0] entry_cnt_q, entry_cnt_d;
    logic [3:0] attempts_q, attempts_d;
    logic [2:0] hits_q, hits_d;
    logic       match_q, match_d;
    logic       result_valid_q, result_valid_d;
    logic       key_err_q, key_err_d;

    logic       can_start;
    logic       round_start;
    logic       in_entry;
    logic       digit_accept;
    logic       digit_reject;
    logic       clear_entry;
    logic [1:0] key_pos;
    logic [3:0] attempts_inc;
    logic [2:0] score_hits;
    logic       score_match;

    guess_score u_score (
        .secret_i (secret_q),
        .guess_i  (guess_q),
        .hits_o   (score_hits),
        .match_o  (score_match)
    );

    assign can_start   = (state_q == S_IDLE) || (state_q == S_ENTRY) ||
                         (state_q == S_WIN)  || (state_q == S_LOCK);
    assign round_start = can_start && start;
    // A new round overrides any key activity in the same cycle.
    assign in_entry     = (state_q == S_ENTRY) && !start;
    assign clear_entry  = in_entry && key_clear;
    assign digit_accept = in_entry && !key_clear && key_valid && (key_digit <= BCD_MAX);
    assign digit_reject = in_entry && !key_clear && key_valid && (key_digit > BCD_MAX);
    assign key_pos      = 2'(2'd3 - entry_cnt_q[1:0]);
    assign attempts_inc = (attempts_q == 4'd15) ? 4'd15 : attempts_q + 4'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_WIN, S_LOCK: begin
                if (start) state_d = S_REQ;
            end
            S_ENTRY: begin
                if (start) begin
                    state_d = S_REQ;
                end else if (digit_accept && (entry_cnt_q == 3'd3)) begin
                    state_d = S_CHECK;
                end
            end
            S_REQ:  state_d = S_WAIT;
            S_WAIT: state_d = S_ENTRY;
            S_CHECK: begin
                if (score_match) begin
                    state_d = S_WIN;
                end else if (attempts_inc == 4'(MAX_TRIES)) begin
                    state_d = S_LOCK;
                end else begin
                    state_d = S_ENTRY;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        fetch_num    = (state_q == S_REQ);
        busy         = (state_q == S_REQ) || (state_q == S_WAIT);
        won          = (state_q == S_WIN);
        locked       = (state_q == S_LOCK);
        entry_count  = entry_cnt_q;
        attempts     = attempts_q;
        hits         = hits_q;
        result_match = match_q;
        result_valid = result_valid_q;
        key_err      = key_err_q;
    end

    always_comb begin
        secret_d       = secret_q;
        guess_d        = guess_q;
        entry_cnt_d    = entry_cnt_q;
        attempts_d     = attempts_q;
        hits_d         = hits_q;
        match_d        = match_q;
        result_valid_d = (state_q == S_CHECK);
        key_err_d      = digit_reject;

        if (state_q == S_WAIT) begin
            secret_d = {rng_d1000, rng_d100, rng_d10, rng_d1};
        end

        if (round_start) begin
            entry_cnt_d = '0;
            attempts_d  = '0;
            hits_d      = '0;
            match_d     = 1'b0;
        end else if (clear_entry) begin
            entry_cnt_d = '0;
        end else if (digit_accept) begin
            guess_d[key_pos] = key_digit;
            entry_cnt_d      = entry_cnt_q + 3'd1;
        end else if (state_q == S_CHECK) begin
            entry_cnt_d = '0;
            attempts_d  = attempts_inc;
            hits_d      = score_hits;
            match_d     = score_match;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            secret_q       <= '0;
            guess_q        <= '0;
            entry_cnt_q    <= '0;
            attempts_q     <= '0;
            hits_q         <= '0;
            match_q        <= 1'b0;
            result_valid_q <= 1'b0;
            key_err_q      <= 1'b0;
        end else begin
            secret_q       <= secret_d;
            guess_q        <= guess_d;
            entry_cnt_q    <= entry_cnt_d;
            attempts_q     <= attempts_d;
            hits_q         <= hits_d;
            match_q        <= match_d;
            result_valid_q <= result_valid_d;
            key_err_q      <= key_err_d;
        end
    end

endmodule

// File: tb/tb_rng_guess_ctrl.sv
// Self-checking bench for rng_guess_ctrl with a game-level reference model.
module tb_rng_guess_ctrl;

    localparam int MAXT = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_digit = '0;
    logic       key_clear = 1'b0;
    logic [3:0] rng_d1000 = '0;
    logic [3:0] rng_d100 = '0;
    logic [3:0] rng_d10 = '0;
    logic [3:0] rng_d1 = '0;
    logic       fetch_num;
    logic       busy;
    logic [2:0] entry_count;
    logic [3:0] attempts;
    logic       result_valid;
    logic       result_match;
    logic [2:0] hits;
    logic       key_err;
    logic       locked;
    logic       won;

    rng_guess_ctrl #(.MAX_TRIES(MAXT)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .key_valid    (key_valid),
        .key_digit    (key_digit),
        .key_clear    (key_clear),
        .rng_d1000    (rng_d1000),
        .rng_d100     (rng_d100),
        .rng_d10      (rng_d10),
        .rng_d1       (rng_d1),
        .fetch_num    (fetch_num),
        .busy         (busy),
        .entry_count  (entry_count),
        .attempts     (attempts),
        .result_valid (result_valid),
        .result_match (result_match),
        .hits         (hits),
        .key_err      (key_err),
        .locked       (locked),
        .won          (won)
    );

    always #5 clk = ~clk;

    // RNG stub: presents the queued digits once it sees a fetch request.
    logic [3:0] stub [4];
    always @(posedge clk) begin
        if (fetch_num) begin
            rng_d1000 <= stub[0];
            rng_d100  <= stub[1];
            rng_d10   <= stub[2];
            rng_d1    <= stub[3];
        end
    end

    // Reference model of the game, thousands digit at index 0.
    int m_secret [4];
    int m_entry [4];
    int m_cnt, m_att, m_hits;
    bit m_match, m_won, m_locked, m_active;

    int n_checks = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_cnt = 0; m_att = 0; m_hits = 0;
        m_match = 0; m_won = 0; m_locked = 0; m_active = 0;
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_cnt"},    32'(entry_count),  32'(m_cnt));
        chk({tag, "_att"},    32'(attempts),     32'(m_att));
        chk({tag, "_hits"},   32'(hits),         32'(m_hits));
        chk({tag, "_match"},  32'(result_match), 32'(m_match));
        chk({tag, "_won"},    32'(won),          32'(m_won));
        chk({tag, "_locked"}, 32'(locked),       32'(m_locked));
        chk({tag, "_busy"},   32'(busy),         0);
        chk({tag, "_fetch"},  32'(fetch_num),    0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_fetch"}, 32'(fetch_num), 0);
        chk({tag, "_busy"},  32'(busy), 0);
        chk({tag, "_cnt"},   32'(entry_count), 0);
        chk({tag, "_att"},   32'(attempts), 0);
        chk({tag, "_rv"},    32'(result_valid), 0);
        chk({tag, "_match"}, 32'(result_match), 0);
        chk({tag, "_hits"},  32'(hits), 0);
        chk({tag, "_kerr"},  32'(key_err), 0);
        chk({tag, "_lock"},  32'(locked), 0);
        chk({tag, "_won"},   32'(won), 0);
    endtask

    task automatic start_round(input int a, input int b, input int c, input int d);
        stub[0] = 4'(a); stub[1] = 4'(b); stub[2] = 4'(c); stub[3] = 4'(d);
        chk("pre_start_fetch", 32'(fetch_num), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("req_fetch", 32'(fetch_num), 1);
        chk("req_busy",  32'(busy), 1);
        tick();
        chk("wait_fetch", 32'(fetch_num), 0);
        chk("wait_busy",  32'(busy), 1);
        tick();
        model_reset();
        m_secret[0] = a; m_secret[1] = b; m_secret[2] = c; m_secret[3] = d;
        m_active = 1;
        check_status("entry");
    endtask

    task automatic press(input int d, input bit clr);
        int h;
        key_valid = 1'b1;
        key_digit = 4'(d);
        key_clear = clr;
        tick();
        key_valid = 1'b0;
        key_clear = 1'b0;
        if (!m_active) begin
            chk("ign_kerr", 32'(key_err), 0);
            chk("ign_rv", 32'(result_valid), 0);
        end else if (clr) begin
            m_cnt = 0;
            chk("clr_kerr", 32'(key_err), 0);
        end else if (d > 9) begin
            chk("bad_kerr", 32'(key_err), 1);
        end else begin
            chk("key_kerr", 32'(key_err), 0);
            m_entry[m_cnt] = d;
            m_cnt++;
            if (m_cnt == 4) begin
                chk("check_cnt4", 32'(entry_count), 4);
                chk("check_rv",   32'(result_valid), 0);
                tick();
                h = 0;
                for (int i = 0; i < 4; i++) if (m_entry[i] == m_secret[i]) h++;
                m_hits  = h;
                m_match = (h == 4);
                m_att   = (m_att < 15) ? m_att + 1 : 15;
                m_cnt   = 0;
                if (m_match) begin
                    m_won = 1; m_active = 0;
                end else if (m_att == MAXT) begin
                    m_locked = 1; m_active = 0;
                end
                chk("result_rv", 32'(result_valid), 1);
                check_status("result");
                tick();
                chk("result_rv_drop", 32'(result_valid), 0);
            end
        end
        check_status("key");
    endtask

    task automatic guess4(input int a, input int b, input int c, input int d);
        press(a, 0); press(b, 0); press(c, 0); press(d, 0);
    endtask

    initial begin
        model_reset();
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_fetch", 32'(fetch_num), 0);
        end

        // Winning round, then keys after the win are ignored.
        start_round(3, 7, 0, 9);
        guess4(3, 7, 0, 9);
        press(5, 0);
        press(12, 0);

        // Two wrong guesses exhaust MAX_TRIES=2.
        start_round(3, 7, 0, 9);
        guess4(1, 7, 5, 9);
        guess4(0, 0, 0, 0);
        press(4, 0);
        start_round(3, 7, 0, 9);
        guess4(0, 0, 0, 0);
        guess4(0, 0, 0, 0);

        // Invalid digit and clear-over-valid priority.
        start_round(1, 2, 3, 4);
        press(1, 0);
        press(2, 0);
        press(12, 0);
        press(5, 1);
        guess4(1, 2, 3, 4);

        // Randomized rounds.
        for (int r = 0; r < 8; r++) begin
            int s [4];
            for (int i = 0; i < 4; i++) s[i] = int'($urandom_range(0, 9));
            start_round(s[0], s[1], s[2], s[3]);
            for (int k = 0; k < 60 && m_active; k++) begin
                int sel;
                sel = int'($urandom_range(0, 99));
                if (sel < 8) press(int'($urandom_range(10, 15)), 0);
                else if (sel < 13) press(int'($urandom_range(0, 15)), 1);
                else if (sel < 60) press(m_secret[m_cnt], 0);
                else press(int'($urandom_range(0, 9)), 0);
            end
            press(int'($urandom_range(0, 9)), 0);
        end

        // Asynchronous reset between edges with a partial guess.
        start_round(5, 5, 5, 5);
        press(5, 0);
        press(1, 0);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all_zero("async_rst");
        tick();
        tick();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_fetch", 32'(fetch_num), 0);
            chk("post_rst_busy", 32'(busy), 0);
        end
        start_round(9, 8, 7, 6);
        guess4(9, 8, 7, 6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
